// File: rtl/fabric_ctrl_pkg.sv
// rtl/fabric_ctrl_pkg.sv - shared state encoding and counter sizing for the fabric controller
package fabric_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    FLUSH,
    CHECK,
    HOLD,
    RUN
  } ctrl_state_e;

  // Never returns zero so a degenerate count still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fabric_ctrl_hold_timer.sv
// rtl/fabric_ctrl_hold_timer.sv - loadable saturating down-counter timing the global set/reset window
module fabric_ctrl_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fabric_global_ctrl.sv
// rtl/fabric_global_ctrl.sv - bitstream loader and global set/reset/clock-enable sequencer for the CLB fabric
module fabric_global_ctrl
  import fabric_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 1024,
  parameter int RST_CYCLES = 16,
  parameter bit INIT_SET   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic prog_start,
  input  logic bs_valid,
  input  logic bs_data,
  output logic bs_ready,
  output logic ccff_head,
  output logic ccff_shift_en,
  input  logic ccff_tail,
  input  logic soft_rst_req,
  output logic fabric_set,
  output logic fabric_reset,
  output logic fabric_clk_en,
  output logic prog_busy,
  output logic prog_done,
  output logic tail_err
);

  localparam int BW = cnt_width(CHAIN_LEN + 1);
  localparam int HW = cnt_width(RST_CYCLES);
  localparam logic [BW-1:0] CHAIN_MAX  = BW'(CHAIN_LEN);
  localparam logic [BW-1:0] CHAIN_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(RST_CYCLES - 1);

  ctrl_state_e   state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          first_bit_q, first_bit_d;
  logic          tail_err_q, tail_err_d;
  logic          ccff_head_q, ccff_shift_en_q;
  logic          fabric_set_q, fabric_reset_q, fabric_clk_en_q;
  logic          prog_busy_q, prog_done_q;
  logic          accept;
  logic          hold_load, hold_dec, hold_zero;

  assign bs_ready = (state_q == SHIFT) && (bit_cnt_q < CHAIN_MAX);
  assign accept   = bs_valid && bs_ready;
  assign hold_dec = (state_q == HOLD);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    first_bit_d = first_bit_q;
    tail_err_d  = tail_err_q;
    hold_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prog_start) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          tail_err_d = 1'b0;
        end
      end
      SHIFT: begin
        if (accept) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == '0) first_bit_d = bs_data;
          if (bit_cnt_q == CHAIN_LAST) state_d = FLUSH;
        end
      end
      FLUSH: state_d = CHECK;
      // After CHAIN_LEN shifts the first bit loaded must be sitting at the tail.
      CHECK: begin
        if (ccff_tail != first_bit_q) tail_err_d = 1'b1;
        hold_load = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (hold_zero) state_d = RUN;
      end
      RUN: begin
        if (prog_start) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          tail_err_d = 1'b0;
        end else if (soft_rst_req) begin
          state_d   = HOLD;
          hold_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Global nets are decoded from the next state so they change together with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      first_bit_q     <= 1'b0;
      tail_err_q      <= 1'b0;
      ccff_head_q     <= 1'b0;
      ccff_shift_en_q <= 1'b0;
      fabric_set_q    <= 1'b1;
      fabric_reset_q  <= 1'b0;
      fabric_clk_en_q <= 1'b0;
      prog_busy_q     <= 1'b0;
      prog_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      first_bit_q     <= first_bit_d;
      tail_err_q      <= tail_err_d;
      ccff_shift_en_q <= accept;
      if (accept) ccff_head_q <= bs_data;
      fabric_clk_en_q <= (state_d == HOLD) || (state_d == RUN);
      fabric_reset_q  <= (state_d == RUN) || ((state_d == HOLD) && INIT_SET);
      fabric_set_q    <= !((state_d == HOLD) && INIT_SET);
      prog_busy_q     <= (state_d == SHIFT) || (state_d == FLUSH) ||
                         (state_d == CHECK) || (state_d == HOLD);
      prog_done_q     <= (state_d == RUN);
    end
  end

  fabric_ctrl_hold_timer #(
    .W(HW)
  ) u_hold_timer (
    .clk       (clk),
    .rst_n     (reset),
    .load_i    (hold_load),
    .load_val_i(HOLD_LOAD),
    .dec_i     (hold_dec),
    .zero_o    (hold_zero)
  );

  assign ccff_head     = ccff_head_q;
  assign ccff_shift_en = ccff_shift_en_q;
  assign fabric_set    = fabric_set_q;
  assign fabric_reset  = fabric_reset_q;
  assign fabric_clk_en = fabric_clk_en_q;
  assign prog_busy     = prog_busy_q;
  assign prog_done     = prog_done_q;
  assign tail_err      = tail_err_q;

endmodule
